// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 memory-stage definitions
// Purpose: FSM state encoding for mem_access_unit and the LC-3 memory-mapped
//          I/O page addresses used when LC3_MMIO_EN is defined.
// Ports:   none (package)
package lc3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [15:0] MMIO_BASE = 16'hFE00;
  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

endpackage

// File: rtl/lc3_mmio_regs.sv
// rtl/lc3_mmio_regs.sv - LC-3 keyboard/display device registers
// Purpose: KBSR/KBDR keyboard latch and DSR/DDR display port. Instantiated by
//          mem_access_unit only when LC3_MMIO_EN is defined.
// Ports:
//   i_CLK, i_RST   clock, asynchronous active-high reset
//   i_acc          one-cycle strobe: an access to the MMIO page is completing
//   i_we           1 = store, 0 = load
//   i_addr         full 16-bit address of the access
//   i_wdata        low byte of store data
//   i_kb_valid     keyboard byte strobe, i_kb_data the byte
//   i_dd_ready     display can accept a byte
//   o_rdata        combinational load data for i_addr
//   o_dd_valid     one-cycle display write pulse, o_dd_data the byte
import lc3_pkg::*;

module lc3_mmio_regs (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_acc,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  input  logic        i_kb_valid,
  input  logic [7:0]  i_kb_data,
  input  logic        i_dd_ready,
  output logic [15:0] o_rdata,
  output logic        o_dd_valid,
  output logic [7:0]  o_dd_data
);

  logic       r_kb_full;
  logic [7:0] r_kbdr;
  logic       r_dd_valid;
  logic [7:0] r_dd_data;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_kb_full  <= 1'b0;
      r_kbdr     <= 8'h00;
      r_dd_valid <= 1'b0;
      r_dd_data  <= 8'h00;
    end else begin
      r_dd_valid <= 1'b0;
      // A new key arriving on the same edge as a KBDR read keeps the flag set.
      if (i_kb_valid) begin
        r_kb_full <= 1'b1;
        r_kbdr    <= i_kb_data;
      end else if (i_acc && !i_we && i_addr == ADDR_KBDR) begin
        r_kb_full <= 1'b0;
      end
      // Display writes never stall; the byte is presented regardless of i_dd_ready.
      if (i_acc && i_we && i_addr == ADDR_DDR) begin
        r_dd_valid <= 1'b1;
        r_dd_data  <= i_wdata;
      end
    end
  end

  always_comb begin
    o_rdata = 16'h0000;
    case (i_addr)
      ADDR_KBSR: o_rdata = {r_kb_full, 15'h0000};
      ADDR_KBDR: o_rdata = {8'h00, r_kbdr};
      ADDR_DSR:  o_rdata = {i_dd_ready, 15'h0000};
      default:   o_rdata = 16'h0000;
    endcase
  end

  assign o_dd_valid = r_dd_valid;
  assign o_dd_data  = r_dd_data;

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - LC-3 MAR/MDR stage in front of the block RAM
// Purpose: accepts one load/store at a time, holds the RAM enable until the
//          RAM ready bit returns (or a timeout), then pulses o_done with data.
//          Macro LC3_MMIO_EN adds the 0xFE00-0xFFFF device page.
// Ports:
//   i_CLK, i_RST              clock, asynchronous active-high reset
//   i_req, i_we, i_addr, i_wdata  request strobe (IDLE only), store flag, MAR, MDR
//   o_busy, o_done, o_err, o_rdata  status, done pulse, error, load result
//   o_mem_*                   RAM enables, addresses and write data
//   i_mem_ready, i_mem_read_data  RAM ready bit and read data
//   i_kb_valid, i_kb_data     keyboard byte (used only with LC3_MMIO_EN)
//   i_dd_ready, o_dd_valid, o_dd_data  display port (tied off without LC3_MMIO_EN)
import lc3_pkg::*;

module mem_access_unit #(
  parameter int AddrBusSize   = 16,
  parameter int MemAddrSize   = 9,
  parameter int ElementSize   = 16,
  parameter int TimeoutCycles = 15
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic                   i_req,
  input  logic                   i_we,
  input  logic [AddrBusSize-1:0] i_addr,
  input  logic [ElementSize-1:0] i_wdata,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [ElementSize-1:0] o_rdata,
  output logic                   o_mem_write_en,
  output logic                   o_mem_read_en,
  output logic [MemAddrSize-1:0] o_mem_write_addr,
  output logic [MemAddrSize-1:0] o_mem_read_addr,
  output logic [ElementSize-1:0] o_mem_write_data,
  input  logic                   i_mem_ready,
  input  logic [ElementSize-1:0] i_mem_read_data,
  input  logic                   i_kb_valid,
  input  logic [7:0]             i_kb_data,
  input  logic                   i_dd_ready,
  output logic                   o_dd_valid,
  output logic [7:0]             o_dd_data
);

  state_t                 r_state;
  state_t                 w_next;
  logic [AddrBusSize-1:0] r_mar;
  logic [ElementSize-1:0] r_mdr;
  logic [ElementSize-1:0] r_rdata;
  logic                   r_we;
  logic                   r_err;
  logic [7:0]             r_timer;

  logic                   w_in_access;
  logic                   w_mmio_hit;
  logic [ElementSize-1:0] w_mmio_rdata;
  logic                   w_range_err;
  logic                   w_bypass;
  logic [ElementSize-1:0] w_bypass_rdata;
  logic                   w_timeout;

  assign w_in_access = (r_state == ST_ACCESS);

`ifdef LC3_MMIO_EN
  assign w_mmio_hit = (r_mar >= AddrBusSize'(MMIO_BASE));

  lc3_mmio_regs u_mmio (
    .i_CLK      (i_CLK),
    .i_RST      (i_RST),
    .i_acc      (w_in_access && w_mmio_hit),
    .i_we       (r_we),
    .i_addr     (r_mar[15:0]),
    .i_wdata    (r_mdr[7:0]),
    .i_kb_valid (i_kb_valid),
    .i_kb_data  (i_kb_data),
    .i_dd_ready (i_dd_ready),
    .o_rdata    (w_mmio_rdata),
    .o_dd_valid (o_dd_valid),
    .o_dd_data  (o_dd_data)
  );
`else
  logic w_unused_mmio;
  assign w_unused_mmio = ^{i_kb_valid, i_kb_data, i_dd_ready};
  assign w_mmio_hit    = 1'b0;
  assign w_mmio_rdata  = '0;
  assign o_dd_valid    = 1'b0;
  assign o_dd_data     = 8'h00;
`endif

  // Addresses outside the RAM that no device claims fail without touching RAM.
  assign w_range_err    = (|(r_mar >> MemAddrSize)) && !w_mmio_hit;
  // Out-of-range and MMIO accesses spend exactly one cycle in ACCESS with both
  // RAM enables held low, giving a fixed o_done in cycle 2.
  assign w_bypass       = w_range_err || w_mmio_hit;
  assign w_bypass_rdata = w_mmio_hit ? w_mmio_rdata : '0;
  // r_timer is 0 in the first ACCESS cycle, so this fires in cycle TimeoutCycles.
  assign w_timeout      = (r_timer == 8'(TimeoutCycles - 1));

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_req) w_next = ST_ACCESS;
      ST_ACCESS: if (w_bypass || i_mem_ready || w_timeout) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy         = (r_state != ST_IDLE);
    o_done         = (r_state == ST_DONE);
    o_err          = (r_state == ST_DONE) && r_err;
    o_mem_write_en = w_in_access && r_we && !w_bypass;
    o_mem_read_en  = w_in_access && !r_we && !w_bypass;
  end

  assign o_mem_write_addr = r_mar[MemAddrSize-1:0];
  assign o_mem_read_addr  = r_mar[MemAddrSize-1:0];
  assign o_mem_write_data = r_mdr;
  assign o_rdata          = r_rdata;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_mar   <= '0;
      r_mdr   <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_timer <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_mar   <= i_addr;
            r_mdr   <= i_wdata;
            r_we    <= i_we;
            r_err   <= 1'b0;
            r_timer <= 8'd0;
          end
        end
        ST_ACCESS: begin
          r_timer <= r_timer + 8'd1;
          if (w_bypass) begin
            r_err <= w_range_err;
            if (!r_we) begin
              r_mdr   <= w_bypass_rdata;
              r_rdata <= w_bypass_rdata;
            end
          end else if (i_mem_ready) begin
            if (!r_we) begin
              r_mdr   <= i_mem_read_data;
              r_rdata <= i_mem_read_data;
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (!r_we) begin
              r_mdr   <= '0;
              r_rdata <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a RAM model
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        busy, done, err;
  logic [15:0] rdata;
  logic        mem_we, mem_re;
  logic [8:0]  mem_waddr, mem_raddr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = 8'h00;
  logic        dd_ready = 1'b0;
  logic        dd_valid;
  logic [7:0]  dd_data;

  mem_access_unit #(
    .AddrBusSize(16), .MemAddrSize(9), .ElementSize(16), .TimeoutCycles(15)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_err(err), .o_rdata(rdata),
    .o_mem_write_en(mem_we), .o_mem_read_en(mem_re),
    .o_mem_write_addr(mem_waddr), .o_mem_read_addr(mem_raddr),
    .o_mem_write_data(mem_wdata), .i_mem_ready(mem_ready), .i_mem_read_data(mem_rdata),
    .i_kb_valid(kb_valid), .i_kb_data(kb_data), .i_dd_ready(dd_ready),
    .o_dd_valid(dd_valid), .o_dd_data(dd_data)
  );

  always #5 clk = ~clk;

  // RAM model: write ready one cycle after write_en, read ready two cycles
  // after read_en; ready falls in any cycle with no enable.
  logic [15:0] ram [0:511];
  int          rd_cnt = 0;
  logic        ram_stall = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready <= 1'b0;
      rd_cnt    <= 0;
      mem_rdata <= 16'h0000;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= ram[mem_raddr];
      if (mem_we) begin
        ram[mem_waddr] <= mem_wdata;
        mem_ready      <= !ram_stall;
      end else if (mem_re) begin
        rd_cnt <= rd_cnt + 1;
        if (rd_cnt == 1) mem_ready <= !ram_stall;
      end
      if (!mem_re) rd_cnt <= 0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_load;
    logic [15:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic en_seen = 1'b0;

  // Monitor: every o_done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (mem_re || mem_we) en_seen = 1'b1;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=pulse at cycle %0d required=no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("err", {31'd0, err}, {31'd0, e.err});
        if (e.is_load) chk("rdata", {16'd0, rdata}, {16'd0, e.rdata});
      end
    end
  end

  // Call at posedge+1 with the DUT idle; this cycle becomes cycle 0.
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, input logic exp_err, input int lat);
    exp_t e;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    e.is_load = !w;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    e.cyc     = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      step();
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    step();
  endtask

  task automatic run_one(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd, input logic exp_err, input int lat);
    issue(w, a, d, exp_rd, exp_err, lat);
    step();
    req = 1'b0;
    drain();
  endtask

  logic [4:0] pat;
  int         c0;

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 16'h0000;
    repeat (3) step();
    chk("reset_ctrl", {26'd0, busy, done, err, mem_we, mem_re, dd_valid}, 32'd0);
    chk("reset_rdata", {16'd0, rdata}, 32'd0);
    chk("reset_addr", {14'd0, mem_waddr, mem_raddr}, 32'd0);
    rst = 1'b0;
    step();

    // Store 0x1234 @0x0005: write_en in cycles 1-2 only, done in cycle 3.
    issue(1'b1, 16'h0005, 16'h1234, 16'h0000, 1'b0, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      pat[k] = mem_we;
      step();
      if (k == 0) req = 1'b0;
    end
    chk("store_we_cycles", {27'd0, pat}, 32'h6);
    chk("sb_after_store", sb.size(), 0);

    run_one(1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0, 4);

    // Top RAM word.
    run_one(1'b1, 16'h01FF, 16'hBEEF, 16'h0000, 1'b0, 3);
    run_one(1'b0, 16'h01FF, 16'h0000, 16'hBEEF, 1'b0, 4);

    // Back-to-back with i_req held: load accepted in cycle 4, done in cycle 8.
    c0 = cyc;
    issue(1'b1, 16'h0010, 16'hA5A5, 16'h0000, 1'b0, 3);
    step();
    begin
      exp_t e;
      we = 1'b0;
      addr = 16'h0010;
      e.is_load = 1'b1;
      e.rdata   = 16'hA5A5;
      e.err     = 1'b0;
      e.cyc     = c0 + 8;
      sb.push_back(e);
    end
    repeat (4) step();
    req = 1'b0;
    drain();

    // Out of RAM range: no enable, done in cycle 2, err, data 0.
    run_one(1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0, 4);
    en_seen = 1'b0;
    run_one(1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1, 2);
    chk("range_no_enable", {31'd0, en_seen}, 32'd0);

`ifndef LC3_MMIO_EN
    en_seen = 1'b0;
    run_one(1'b0, 16'hFE00, 16'h0000, 16'h0000, 1'b1, 2);
    chk("page_no_enable", {31'd0, en_seen}, 32'd0);
`endif

    // RAM never ready: 15 ACCESS cycles, done in cycle 16, err, load data 0.
    run_one(1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0, 4);
    ram_stall = 1'b1;
    run_one(1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b1, 16);
    ram_stall = 1'b0;

    // Reset during cycle 1 of a load: enable drops at once, no done pulse.
    req  = 1'b1;
    we   = 1'b0;
    addr = 16'h0005;
    step();
    req = 1'b0;
    chk("rst_pre_read_en", {31'd0, mem_re}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_read_en", {31'd0, mem_re}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    repeat (8) step();
    chk("rst_idle_busy", {31'd0, busy}, 32'd0);

`ifdef LC3_MMIO_EN
    kb_data  = 8'h41;
    kb_valid = 1'b1;
    step();
    kb_valid = 1'b0;
    run_one(1'b0, 16'hFE00, 16'h0000, 16'h8000, 1'b0, 2);
    run_one(1'b0, 16'hFE02, 16'h0000, 16'h0041, 1'b0, 2);
    run_one(1'b0, 16'hFE00, 16'h0000, 16'h0000, 1'b0, 2);
    issue(1'b1, 16'hFE06, 16'h0058, 16'h0000, 1'b0, 2);
    step();
    req = 1'b0;
    step();
    @(negedge clk);
    chk("dd_valid", {31'd0, dd_valid}, 32'd1);
    chk("dd_data", {24'd0, dd_data}, 32'h58);
    step();
    drain();
`endif

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
